swipt_adc_sequencer: RTL and testbench
======================================

// Module: swipt_adc_sequencer
// PURPOSE
// - Time-shares the single SWIPT ADC between internal requesters (frequency tracker: AC current 7'h16; power/data path: DC current 7'h1E).
// - Drives ADC_address_swipt and waits for the mux to settle after a channel change.
// - Averages 2^AVG_LOG2 consecutive ADC_in samples and returns the mean to the granted requester.
// - Sits between the freq/optimization/data blocks and the swipt_toplevel ADC pins.
// PARAMETERS
// N_REQ          2      number of requesters (>=2)
// ADC_W          12     ADC_in width
// ADDR_W         7      ADC channel address width
// SETTLE_CYCLES  16     clk cycles waited after an address change (>=1)
// AVG_LOG2       2      log2 of samples averaged per request (0..4)
// DEF_ADDR       7'h1E  address driven out of reset (DC current)
// PORTS
// clk                input   1             system clock, all logic on posedge
// nrst               input   1             asynchronous active-low reset
// enable             input   1             swiptAlive; low aborts/blocks all grants
// req                input   N_REQ         level request per requester, held until rsp_valid
// req_addr           input   N_REQ*ADDR_W  channel per requester, slice i = [i*ADDR_W +: ADDR_W]
// ADC_in             input   ADC_W         raw ADC sample
// ADC_address_swipt  output  ADDR_W        ADC channel select
// gnt                output  N_REQ         one-hot, high while requester i owns the ADC
// rsp_valid          output  N_REQ         one-cycle pulse, mean on rsp_data valid for requester i
// rsp_data           output  ADC_W         averaged sample, shared, valid only with rsp_valid
// busy               output  1             high in any state other than IDLE
// BEHAVIOUR
// - Reset values: ADC_address_swipt=DEF_ADDR, gnt=0, rsp_valid=0, rsp_data=0, busy=0, rr pointer=0, state=IDLE.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE.
// - IDLE: on an edge with enable=1 and req!=0, grant the first set req bit at or after rr pointer (wrapping).
//   - Same edge: gnt<=onehot(i), ADC_address_swipt<=req_addr[i].
//   - Next state is SETTLE if the address changed, else SAMPLE (settle skipped).
// - SETTLE: counts SETTLE_CYCLES edges, then goes to SAMPLE; the address is frozen.
// - SAMPLE: accumulates ADC_in on 2^AVG_LOG2 consecutive edges into acc[ADC_W+AVG_LOG2-1:0], zeroed on entry.
//   - After the last sample -> DONE.
// - DONE (one cycle):
//   - rsp_data<=acc>>AVG_LOG2 (truncating, no rounding) and rsp_valid[i]=1.
//   - gnt<=0; rr pointer<=(i+1) mod N_REQ; next state IDLE.
// - Latency, req rise to rsp_valid: 1+SETTLE_CYCLES+2^AVG_LOG2+1 edges (defaults: 22); without address change: 2^AVG_LOG2+2 (defaults: 6).
// - Back-to-back: IDLE lasts at least one cycle between grants; the requester must drop req within one cycle of rsp_valid.
// - Abort: req[i] low or enable low while in SETTLE/SAMPLE/DONE-entry -> state IDLE next edge.
//   - gnt<=0, no rsp_valid, rr pointer advances past i; ADC_address_swipt keeps its current value.
// - Simultaneous requests: round-robin, so no requester is granted twice while another waits.
// - req_addr changes while granted are ignored until the next grant.
// - Reset mid-operation: everything returns to reset values immediately, including address=DEF_ADDR.
// STRUCTURE
// - Shared package: FSM state encoding (2-bit), ADC channel constants ADDR_AC_CURR=7'h16 and ADDR_DC_CURR=7'h1E.
// - One sub-module: swipt_rr_pick (combinational round-robin first-set finder over req with pointer); FSM, counters and accumulator stay in this module.
// TESTING
// 1 Reset: nrst low mid-SAMPLE -> ADC_address_swipt=7'h1E, gnt=0, busy=0 within the same cycle; no rsp_valid after release.
// 2 Single req[0], addr 7'h16, ADC_in=100,104,108,112 during SAMPLE -> rsp_valid[0] 22 edges after req, rsp_data=106.
// 3 req[1] with addr 7'h1E equal to the current address -> no SETTLE, rsp_valid[1] after 6 edges.
// 4 req=2'b11 held continuously, rr=0 -> grant order 0,1,0,1; each gnt one-hot, never overlapping.
// 5 enable dropped 5 cycles into SETTLE -> state IDLE next edge, gnt=0, no rsp_valid, address stays 7'h16.
// 6 ADC_in=12'hFFF on all samples -> rsp_data=12'hFFF (no accumulator overflow).

Source files
------------

// File: rtl/swipt_adc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// swipt_adc_sequencer_pkg
// Shared definitions for the SWIPT ADC sequencer: the 2-bit FSM state encoding
// and the ADC channel addresses used by the internal requesters.
// -----------------------------------------------------------------------------
package swipt_adc_sequencer_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for a request
    ST_SETTLE = 2'd1,  // mux settling after an address change
    ST_SAMPLE = 2'd2,  // accumulating ADC samples
    ST_DONE   = 2'd3   // returning the mean to the owner
  } state_e;

  // ADC channel addresses.
  localparam logic [6:0] ADDR_AC_CURR = 7'h16;  // frequency tracker: AC current
  localparam logic [6:0] ADDR_DC_CURR = 7'h1E;  // power/data path: DC current

endpackage : swipt_adc_sequencer_pkg

// File: rtl/swipt_adc_sequencer_rr_pick.sv
// -----------------------------------------------------------------------------
// swipt_rr_pick
// Combinational round-robin finder: returns the first set bit of req at or
// after ptr, wrapping around from N-1 to 0.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [PTR_W-1:0]  round-robin start position (0..N-1)
//   found              at least one request bit is set
//   idx   [PTR_W-1:0]  index of the selected request (0 when found=0)
// -----------------------------------------------------------------------------
module swipt_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  // Scan from the farthest position back to ptr so the candidate closest to
  // ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = PTR_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule : swipt_rr_pick

// File: rtl/swipt_adc_sequencer.sv
// -----------------------------------------------------------------------------
// swipt_adc_sequencer
// Time-shares the single SWIPT ADC between internal requesters. A granted
// requester gets the ADC mux switched to its channel, a settle wait when the
// channel actually changed, and the truncated mean of 2^AVG_LOG2 consecutive
// samples returned with a one-cycle rsp_valid pulse.
// Ports:
//   clk                system clock, all logic on posedge
//   nrst               asynchronous active-low reset
//   enable             swiptAlive; low aborts the current grant and blocks new ones
//   req       [N]      level request per requester, held until rsp_valid
//   req_addr  [N*A]    channel per requester, slice i = [i*ADDR_W +: ADDR_W]
//   ADC_in    [ADC_W]  raw ADC sample
//   ADC_address_swipt  ADC channel select
//   gnt       [N]      one-hot, high while requester i owns the ADC
//   rsp_valid [N]      one-cycle pulse, rsp_data valid for requester i
//   rsp_data  [ADC_W]  averaged sample, valid only with rsp_valid
//   busy               high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module swipt_adc_sequencer
  import swipt_adc_sequencer_pkg::*;
#(
  parameter int                N_REQ         = 2,
  parameter int                ADC_W         = 12,
  parameter int                ADDR_W        = 7,
  parameter int                SETTLE_CYCLES = 16,
  parameter int                AVG_LOG2      = 2,
  parameter logic [ADDR_W-1:0] DEF_ADDR      = ADDR_W'(ADDR_DC_CURR)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [ADC_W-1:0]        ADC_in,
  output logic [ADDR_W-1:0]       ADC_address_swipt,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [ADC_W-1:0]        rsp_data,
  output logic                    busy
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int N_SAMP  = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYCLES > N_SAMP) ? SETTLE_CYCLES : N_SAMP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ACC_W   = ADC_W + AVG_LOG2;  // wide enough for N_SAMP full-scale samples

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [ADC_W-1:0]    rsp_data_q, rsp_data_d;

  logic                pick_found;
  logic [PTR_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   cand_addr;
  logic [PTR_W-1:0]    owner_inc;
  logic                grant;
  logic                abort;

  swipt_rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cand_addr = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign owner_inc = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  assign grant     = enable && pick_found;
  // The owner withdrawing its request or swiptAlive dropping ends the grant.
  assign abort     = !enable || !req[owner_q];

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: flops use non-blocking assignments so every register samples
      // pre-edge values regardless of process ordering.
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Settle is skipped when the winner wants the channel already selected.
        if (grant) state_d = (cand_addr != addr_q) ? ST_SETTLE : ST_SAMPLE;
      end
      ST_SETTLE: begin
        if (abort)                                     state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))   state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                                     state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(N_SAMP - 1))          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d     = owner_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    gnt_d       = gnt_q;
    acc_d       = acc_q;
    cnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = pick_idx;
          addr_d  = cand_addr;  // captured once; later req_addr changes are ignored
          gnt_d   = N_REQ'(1) << pick_idx;
        end
      end
      ST_SETTLE, ST_SAMPLE: begin
        if (abort) begin
          // Address is left as is; only the grant is withdrawn.
          gnt_d = '0;
          rr_d  = owner_inc;
        end else if (state_q == ST_SAMPLE) begin
          acc_d = acc_q + ACC_W'(ADC_in);
        end
      end
      ST_DONE: begin
        gnt_d = '0;
        rr_d  = owner_inc;
        if (!abort) begin
          rsp_valid_d = N_REQ'(1) << owner_q;
          rsp_data_d  = ADC_W'(acc_q >> AVG_LOG2);  // truncating mean
        end
      end
      default: ;
    endcase
    if (state_d == ST_SAMPLE && state_q != ST_SAMPLE) acc_d = '0;
    // One counter serves both timed states; it restarts on every state change.
    if (state_d == state_q && (state_q == ST_SETTLE || state_q == ST_SAMPLE))
      cnt_d = cnt_q + CNT_W'(1);
    busy = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      owner_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      addr_q      <= DEF_ADDR;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ADC_address_swipt = addr_q;
  assign gnt               = gnt_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;

endmodule : swipt_adc_sequencer

// File: tb/tb_swipt_adc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_swipt_adc_sequencer
// Directed scenarios followed by randomized traffic, with every cycle compared
// against a transaction-level reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_swipt_adc_sequencer;
  import swipt_adc_sequencer_pkg::*;

  localparam int N_REQ    = 2;
  localparam int ADC_W    = 12;
  localparam int ADDR_W   = 7;
  localparam int SETTLE   = 16;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 1 << AVG_LOG2;

  logic                    clk = 1'b0;
  logic                    nrst = 1'b0;
  logic                    enable = 1'b0;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [ADC_W-1:0]        adc_in = '0;
  logic [ADDR_W-1:0]       adc_addr;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rsp_valid;
  logic [ADC_W-1:0]        rsp_data;
  logic                    busy;

  swipt_adc_sequencer #(
    .N_REQ         (N_REQ),
    .ADC_W         (ADC_W),
    .ADDR_W        (ADDR_W),
    .SETTLE_CYCLES (SETTLE),
    .AVG_LOG2      (AVG_LOG2),
    .DEF_ADDR      (ADDR_DC_CURR)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .enable            (enable),
    .req               (req),
    .req_addr          (req_addr),
    .ADC_in            (adc_in),
    .ADC_address_swipt (adc_addr),
    .gnt               (gnt),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one transaction at a time. A grant at edge g owns the ADC,
  // samples ADC_in on edges g+S+1 .. g+S+NS (S = SETTLE if the channel changed,
  // else 0) and answers on edge g+S+NS+1 unless req/enable drop first.
  // ---------------------------------------------------------------------------
  int               m_edge = 0;
  int               m_owner = -1;
  int               m_rr = 0;
  int               m_start = 0;
  int               m_settle = 0;
  int               m_sum = 0;
  int               m_pick;
  logic [ADDR_W-1:0] m_addr = ADDR_DC_CURR;
  logic [N_REQ-1:0] m_rsp_valid = '0;
  logic [ADC_W-1:0] m_rsp_data = '0;

  initial forever begin
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      m_edge = 0; m_owner = -1; m_rr = 0; m_sum = 0;
      m_addr = ADDR_DC_CURR; m_rsp_valid = '0; m_rsp_data = '0;
    end else begin
      m_edge++;
      m_rsp_valid = '0;
      if (m_owner >= 0) begin
        if (!enable || !req[m_owner]) begin
          m_rr    = (m_owner + 1) % N_REQ;
          m_owner = -1;
        end else if (m_edge == m_start + m_settle + NS + 1) begin
          m_rsp_valid[m_owner] = 1'b1;
          m_rsp_data           = ADC_W'(m_sum / NS);
          m_rr                 = (m_owner + 1) % N_REQ;
          m_owner              = -1;
        end else if (m_edge > m_start + m_settle) begin
          m_sum += int'(adc_in);
        end
      end else if (enable && req != '0) begin
        m_pick = -1;
        for (int k = N_REQ - 1; k >= 0; k--)
          if (req[(m_rr + k) % N_REQ]) m_pick = (m_rr + k) % N_REQ;
        m_owner  = m_pick;
        m_start  = m_edge;
        m_sum    = 0;
        m_settle = (req_addr[m_pick*ADDR_W +: ADDR_W] != m_addr) ? SETTLE : 0;
        m_addr   = req_addr[m_pick*ADDR_W +: ADDR_W];
      end
    end
  end

  // Cycle scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    check("addr", 32'(adc_addr), 32'(m_addr));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid != '0) check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wait_rsp(input int i, input int max_edges, output int lat);
    lat = -1;
    for (int k = 1; k <= max_edges; k++) begin
      tick();
      if (rsp_valid[i]) begin
        lat = k;
        return;
      end
    end
  endtask

  int lat;
  int n_rsp;
  int n_gr;
  int order [4];
  logic [N_REQ-1:0] prev_gnt;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    nrst   = 1'b1;
    enable = 1'b1;
    check("reset_addr", 32'(adc_addr), 32'h1E);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick();

    // Same channel as the reset default: settle skipped.
    set_addr(1, ADDR_DC_CURR); req[1] = 1'b1;
    wait_rsp(1, 40, lat);
    req[1] = 1'b0;
    check("same_addr_latency", 32'(lat), 32'd6);
    tick();

    // Channel change with a known sample ramp.
    set_addr(0, ADDR_AC_CURR); req[0] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      adc_in = (k >= 18 && k <= 21) ? ADC_W'(100 + 4 * (k - 18)) : ADC_W'($urandom);
      tick();
      if (rsp_valid[0]) begin
        lat = k;
        break;
      end
    end
    req[0] = 1'b0;
    check("settle_latency", 32'(lat), 32'd22);
    check("settle_mean", 32'(rsp_data), 32'd106);
    tick();

    // Full-scale samples must not overflow the average.
    adc_in = 12'hFFF;
    set_addr(1, ADDR_AC_CURR); req[1] = 1'b1;
    wait_rsp(1, 40, lat);
    req[1] = 1'b0;
    check("fullscale_latency", 32'(lat), 32'd6);
    check("fullscale_mean", 32'(rsp_data), 32'hFFF);
    tick();

    // Both requesting continuously: strict alternation starting at 0.
    set_addr(0, ADDR_DC_CURR); set_addr(1, ADDR_DC_CURR);
    req = 2'b11; prev_gnt = '0; n_gr = 0;
    for (int k = 0; k < 200 && n_gr < 4; k++) begin
      tick();
      if (prev_gnt == '0 && gnt != '0) begin
        order[n_gr] = gnt[1] ? 1 : 0;
        n_gr++;
      end
      prev_gnt = gnt;
    end
    req = '0;
    check("rr_grant_count", 32'(n_gr), 32'd4);
    for (int j = 0; j < n_gr; j++) check("rr_order", 32'(order[j]), 32'(j % 2));
    repeat (3) tick();

    // enable drops five edges into SETTLE.
    set_addr(0, ADDR_AC_CURR); req[0] = 1'b1;
    tick();
    check("abort_granted", 32'(gnt), 32'b01);
    repeat (5) tick();
    check("abort_settling", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(adc_addr), 32'h16);
    n_rsp = 0;
    repeat (25) begin
      tick();
      if (rsp_valid != '0) n_rsp++;
    end
    check("abort_no_rsp", 32'(n_rsp), 32'd0);
    req[0] = 1'b0; enable = 1'b1;
    tick();

    // Reset asserted in the middle of SAMPLE.
    set_addr(0, ADDR_AC_CURR); req[0] = 1'b1;
    repeat (3) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("midreset_addr", 32'(adc_addr), 32'h1E);
    check("midreset_gnt", 32'(gnt), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    tick();
    nrst = 1'b1;
    n_rsp = 0;
    repeat (25) begin
      tick();
      if (rsp_valid != '0) n_rsp++;
    end
    check("postreset_no_rsp", 32'(n_rsp), 32'd0);

    // Randomized traffic checked by the cycle scoreboard.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      adc_in = ADC_W'($urandom);
      enable = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if (rsp_valid[i] || $urandom_range(0, 99) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 9) == 0) set_addr(i, ADDR_W'($urandom));
        end else if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 2))
            0:       set_addr(i, ADDR_AC_CURR);
            1:       set_addr(i, ADDR_DC_CURR);
            default: set_addr(i, ADDR_W'($urandom));
          endcase
          req[i] = 1'b1;
        end
      end
      tick();
    end
    req = '0;
    enable = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_swipt_adc_sequencer
